// File: rtl/mem_requester_if.sv
// Memory-side bus of mem_requester: ownership handshake plus the memory
// control/address/data lines. The requester is the master; the memory/arbiter side is the slave.
interface mem_requester_if;
    logic        bus_req;
    logic        bus_grant;
    logic [1:0]  mem_control;
    logic [63:0] mem_addr;
    logic [63:0] mem_datIn;
    logic        mem_arbiter;
    logic [63:0] mem_wb_data;
    logic        mem_ready;

    modport master (
        output bus_req,
        output mem_control,
        output mem_addr,
        output mem_datIn,
        output mem_arbiter,
        input  bus_grant,
        input  mem_wb_data,
        input  mem_ready
    );

    modport slave (
        input  bus_req,
        input  mem_control,
        input  mem_addr,
        input  mem_datIn,
        input  mem_arbiter,
        output bus_grant,
        output mem_wb_data,
        output mem_ready
    );
endinterface

// File: rtl/mem_requester.sv
// Single-outstanding load/store requester: takes one pipeline memory op,
// arbitrates for the memory, performs the access with a timeout and reports completion.
module mem_requester #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [1:0]            op_type,
    input  logic [63:0]           op_addr,
    input  logic [63:0]           op_data,
    output logic                  stall,
    output logic [63:0]           ld_data,
    output logic                  ld_valid,
    output logic                  done,
    output logic                  err,
    output logic                  err_sticky,
    mem_requester_if.master       mem
);

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic [1:0]  type_r;
    logic [63:0] addr_r;
    logic [63:0] data_r;

    logic        legal_s;
    logic        aligned_s;
    logic        capture_s;
    logic        fail_s;
    logic        ld_capture_s;
    logic        access_next_s;
    logic        busy_next_s;

    logic        stall_r;
    logic [63:0] ld_data_r;
    logic        ld_valid_r;
    logic        done_r;
    logic        err_r;
    logic        err_sticky_r;
    logic        bus_req_r;
    logic [1:0]  mem_control_r;
    logic [63:0] mem_addr_r;
    logic [63:0] mem_datIn_r;
    logic        mem_arbiter_r;

    assign legal_s   = op_valid & ((op_type == OP_LOAD) | (op_type == OP_STORE));
    assign aligned_s = (op_addr[2:0] == 3'b000);

    // Next-state, access counter and the events that decide the DONE outcome
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        capture_s    = 1'b0;
        fail_s       = 1'b0;
        ld_capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (legal_s) begin
                    if (aligned_s) begin
                        state_s   = ST_REQ;
                        capture_s = 1'b1;
                    end else begin
                        state_s = ST_DONE;
                        fail_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.bus_grant) begin
                    state_s = ST_ACCESS;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACCESS: begin
                // A ready in the final allowed cycle still counts as success
                if (mem.mem_ready) begin
                    state_s      = ST_DONE;
                    ld_capture_s = (type_r == OP_LOAD);
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    fail_s  = 1'b1;
                end else begin
                    state_s = ST_ACCESS;
                    cnt_s   = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    assign access_next_s = (state_s == ST_ACCESS);
    assign busy_next_s   = (state_s == ST_REQ) | (state_s == ST_ACCESS);

    // State register, latched operation and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            type_r        <= OP_NONE;
            addr_r        <= 64'd0;
            data_r        <= 64'd0;
            stall_r       <= 1'b0;
            ld_data_r     <= 64'd0;
            ld_valid_r    <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            err_sticky_r  <= 1'b0;
            bus_req_r     <= 1'b0;
            mem_control_r <= 2'b00;
            mem_addr_r    <= 64'd0;
            mem_datIn_r   <= 64'd0;
            mem_arbiter_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (capture_s) begin
                type_r <= op_type;
                addr_r <= op_addr;
                data_r <= op_data;
            end
            if (ld_capture_s) begin
                ld_data_r <= mem.mem_wb_data;
            end
            stall_r       <= busy_next_s;
            ld_valid_r    <= ld_capture_s;
            done_r        <= (state_s == ST_DONE);
            err_r         <= fail_s;
            err_sticky_r  <= err_sticky_r | fail_s;
            bus_req_r     <= busy_next_s;
            mem_arbiter_r <= access_next_s;
            mem_control_r <= access_next_s ? type_r : OP_NONE;
            mem_addr_r    <= access_next_s ? addr_r : 64'd0;
            mem_datIn_r   <= access_next_s ? data_r : 64'd0;
        end
    end

    // The pipeline must be held in the same cycle a legal op is presented
    assign stall           = stall_r | ((state_r == ST_IDLE) & legal_s);
    assign ld_data         = ld_data_r;
    assign ld_valid        = ld_valid_r;
    assign done            = done_r;
    assign err             = err_r;
    assign err_sticky      = err_sticky_r;
    assign mem.bus_req     = bus_req_r;
    assign mem.mem_control = mem_control_r;
    assign mem.mem_addr    = mem_addr_r;
    assign mem.mem_datIn   = mem_datIn_r;
    assign mem.mem_arbiter = mem_arbiter_r;

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: directed vector table, hand-written
// reset/handshake sequences and randomized ops against a transaction-level model.
module tb_mem_requester;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [63:0] op_addr;
    logic [63:0] op_data;
    logic        stall;
    logic [63:0] ld_data;
    logic        ld_valid;
    logic        done;
    logic        err;
    logic        err_sticky;

    mem_requester_if bus();

    mem_requester #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_type    (op_type),
        .op_addr    (op_addr),
        .op_data    (op_data),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] ld_m;
    logic        sticky_m;

    typedef struct {
        logic [1:0]  typ;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] wb;
        int          gd;
        int          rd;
        logic        e_err;
        logic        e_ldv;
        logic [63:0] e_ld;
        int          e_req;
        int          e_acc;
    } vec_t;

    vec_t vt[7];

    logic        g_err, g_ldv, g_sticky;
    logic [63:0] g_ld;
    int          g_req, g_acc, g_stl;
    logic [1:0]  r_typ;
    logic [63:0] r_addr, r_data, r_wb;
    int          r_gd, r_rd;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_ld_data"}, ld_data, 64'd0);
        check({tag, "_ld_valid"}, 64'(ld_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
        check({tag, "_bus_req"}, 64'(bus.bus_req), 64'd0);
        check({tag, "_mem_control"}, 64'(bus.mem_control), 64'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
        check({tag, "_mem_datIn"}, bus.mem_datIn, 64'd0);
        check({tag, "_mem_arbiter"}, 64'(bus.mem_arbiter), 64'd0);
    endtask

    // Presents one op and plays the memory/arbiter side until done (bounded).
    task automatic run_op(input logic [1:0] typ, input logic [63:0] addr, data, wb,
                          input int gd, rd, input bit hold,
                          output logic o_err, o_ldv, output logic [63:0] o_ld, output logic o_sticky,
                          output int o_req, o_acc, o_stl);
        bit fin;
        fin = 1'b0; o_err = 1'b0; o_ldv = 1'b0; o_ld = 64'd0; o_sticky = 1'b0;
        o_req = 0; o_acc = 0; o_stl = 0;
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = typ; op_addr = addr; op_data = data;
        #1 check("stall_on_accept", 64'(stall), 64'd1);
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 2'b00; op_addr = 64'd0; op_data = 64'd0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            bus.bus_grant = 1'b0;
            bus.mem_ready = 1'b0;
            bus.mem_wb_data = {$urandom(), $urandom()};
            if (done) begin
                fin = 1'b1;
                o_err = err; o_ldv = ld_valid; o_ld = ld_data; o_sticky = err_sticky;
                check("done_stall", 64'(stall), 64'd0);
                check("done_mem_control", 64'(bus.mem_control), 64'd0);
                check("done_mem_arbiter", 64'(bus.mem_arbiter), 64'd0);
            end else begin
                if (stall) o_stl++;
                if (bus.mem_arbiter) begin
                    o_acc++;
                    check("acc_mem_control", 64'(bus.mem_control), 64'(typ));
                    check("acc_mem_addr", bus.mem_addr, addr);
                    check("acc_mem_datIn", bus.mem_datIn, data);
                    check("acc_bus_req", 64'(bus.bus_req), 64'd1);
                    bus.bus_grant = 1'($urandom_range(0, 1));
                    if (o_acc == rd + 1) begin
                        bus.mem_ready = 1'b1;
                        bus.mem_wb_data = wb;
                    end
                end else if (bus.bus_req) begin
                    o_req++;
                    check("req_mem_control", 64'(bus.mem_control), 64'd0);
                    check("req_mem_addr", bus.mem_addr, 64'd0);
                    if (o_req > gd) bus.bus_grant = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        bus.bus_grant = 1'b0;
        bus.mem_ready = 1'b0;
        if (!fin) check("op_completion_bound", 64'd0, 64'd1);
        if (hold) begin
            op_valid = 1'b1; op_type = 2'b01; op_addr = 64'h18; op_data = 64'd0;
            #1 check("done_no_accept_stall", 64'(stall), 64'd0);
        end
        @(posedge clk); #1;
        check("done_pulse_width", 64'(done), 64'd0);
        check("ld_valid_pulse_width", 64'(ld_valid), 64'd0);
        check("err_pulse_width", 64'(err), 64'd0);
        if (hold) begin
            check("done_no_accept_bus_req", 64'(bus.bus_req), 64'd0);
            check("idle_legal_stall", 64'(stall), 64'd1);
        end
    endtask

    // Transaction-level expectation: outcome follows from alignment, grant delay and ready delay.
    task automatic model_op(input string tag, input logic [1:0] typ, input logic [63:0] addr, data, wb,
                            input int gd, rd, input bit hold);
        logic e_err, e_ldv;
        int   e_req, e_acc;
        if (addr[2:0] != 3'b000) begin
            e_err = 1'b1; e_ldv = 1'b0; e_req = 0; e_acc = 0;
        end else begin
            e_req = gd + 1;
            if (rd < int'(TO)) begin
                e_acc = rd + 1; e_err = 1'b0; e_ldv = (typ == 2'b01);
                if (e_ldv) ld_m = wb;
            end else begin
                e_acc = int'(TO); e_err = 1'b1; e_ldv = 1'b0;
            end
        end
        sticky_m = sticky_m | e_err;
        run_op(typ, addr, data, wb, gd, rd, hold, g_err, g_ldv, g_ld, g_sticky, g_req, g_acc, g_stl);
        check({tag, "_err"}, 64'(g_err), 64'(e_err));
        check({tag, "_ld_valid"}, 64'(g_ldv), 64'(e_ldv));
        check({tag, "_ld_data"}, g_ld, ld_m);
        check({tag, "_req_cycles"}, 64'(g_req), 64'(e_req));
        check({tag, "_access_cycles"}, 64'(g_acc), 64'(e_acc));
        check({tag, "_stall_cycles"}, 64'(g_stl), 64'(e_req + e_acc));
        check({tag, "_err_sticky"}, 64'(g_sticky), 64'(sticky_m));
    endtask

    task automatic idle_op(input logic v, input logic [1:0] typ);
        @(posedge clk); #1;
        op_valid = v; op_type = typ; op_addr = 64'h40; op_data = 64'd0;
        #1 check("non_op_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 2'b00;
        check("non_op_bus_req", 64'(bus.bus_req), 64'd0);
        check("non_op_done", 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_addr = 64'd0; op_data = 64'd0;
        bus.bus_grant = 1'b0; bus.mem_ready = 1'b0; bus.mem_wb_data = 64'd0;
        ld_m = 64'd0; sticky_m = 1'b0;

        vt[0] = '{2'b01, 64'h40,  64'h0,    64'hDEADBEEF,          0, 2,   1'b0, 1'b1, 64'hDEADBEEF,          1, 3};
        vt[1] = '{2'b10, 64'h08,  64'h1234, 64'hBADBADBADBADBAD0,  5, 0,   1'b0, 1'b0, 64'hDEADBEEF,          6, 1};
        vt[2] = '{2'b01, 64'h0C,  64'h0,    64'h1111,              0, 0,   1'b1, 1'b0, 64'hDEADBEEF,          0, 0};
        vt[3] = '{2'b01, 64'h100, 64'h0,    64'h2222,              0, 200, 1'b1, 1'b0, 64'hDEADBEEF,          1, 4};
        vt[4] = '{2'b01, 64'h108, 64'h0,    64'h0123456789ABCDEF,  1, 3,   1'b0, 1'b1, 64'h0123456789ABCDEF,  2, 4};
        vt[5] = '{2'b10, 64'h13,  64'h77,   64'h3333,              0, 0,   1'b1, 1'b0, 64'h0123456789ABCDEF,  0, 0};
        vt[6] = '{2'b10, 64'hFF8, 64'h99,   64'h4444,              2, 200, 1'b1, 1'b0, 64'h0123456789ABCDEF,  3, 4};

        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].typ, vt[i].addr, vt[i].data, vt[i].wb, vt[i].gd, vt[i].rd, 1'b0,
                   g_err, g_ldv, g_ld, g_sticky, g_req, g_acc, g_stl);
            sticky_m = sticky_m | vt[i].e_err;
            ld_m = vt[i].e_ld;
            check($sformatf("vec%0d_err", i), 64'(g_err), 64'(vt[i].e_err));
            check($sformatf("vec%0d_ld_valid", i), 64'(g_ldv), 64'(vt[i].e_ldv));
            check($sformatf("vec%0d_ld_data", i), g_ld, vt[i].e_ld);
            check($sformatf("vec%0d_req_cycles", i), 64'(g_req), 64'(vt[i].e_req));
            check($sformatf("vec%0d_access_cycles", i), 64'(g_acc), 64'(vt[i].e_acc));
            check($sformatf("vec%0d_stall_cycles", i), 64'(g_stl), 64'(vt[i].e_req + vt[i].e_acc));
            check($sformatf("vec%0d_err_sticky", i), 64'(g_sticky), 64'(sticky_m));
        end

        idle_op(1'b1, 2'b00);
        idle_op(1'b1, 2'b11);
        idle_op(1'b0, 2'b01);

        model_op("hold_store", 2'b10, 64'h20, 64'hCAFE, 64'h0, 0, 1, 1'b1);
        model_op("after_done_load", 2'b01, 64'h18, 64'h0, 64'h5555AAAA5555AAAA, 0, 0, 1'b0);

        // Reset in the middle of an access
        @(posedge clk); #1;
        op_valid = 1'b1; op_type = 2'b01; op_addr = 64'h80; op_data = 64'd0;
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 2'b00; op_addr = 64'd0;
        bus.bus_grant = 1'b1;
        @(posedge clk); #1;
        bus.bus_grant = 1'b0;
        check("rst_pre_access_arbiter", 64'(bus.mem_arbiter), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_zero("rst_mid_access");
        ld_m = 64'd0; sticky_m = 1'b0;
        @(posedge clk); #1;
        check("rst_no_done", 64'(done), 64'd0);
        check("rst_no_err", 64'(err), 64'd0);
        check("rst_no_ld_valid", 64'(ld_valid), 64'd0);
        check("rst_idle_bus_req", 64'(bus.bus_req), 64'd0);
        model_op("post_rst_load", 2'b01, 64'h80, 64'h0, 64'hFEEDFACE00C0FFEE, 1, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_typ  = 2'($urandom_range(0, 3));
            r_addr = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) r_addr[2:0] = 3'b000;
            else if (r_addr[2:0] == 3'b000) r_addr[0] = 1'b1;
            r_data = {$urandom(), $urandom()};
            r_wb   = {$urandom(), $urandom()};
            r_gd   = int'($urandom_range(0, 3));
            r_rd   = int'($urandom_range(0, 5));
            if (r_typ == 2'b01 || r_typ == 2'b10)
                model_op($sformatf("rnd%0d", i), r_typ, r_addr, r_data, r_wb, r_gd, r_rd, 1'b0);
            else
                idle_op(1'b1, r_typ);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
